// File: rtl/dcache_refill_ctrl_if.sv
// Bundle of the cache-miss, memory request/response and line-fill signals
// around dcache_refill_ctrl.
//   master : the refill controller (drives miss_ready, mem_req_*, fill_*, crit_*, busy)
//   slave  : the surrounding cache and memory (drives miss_*, mem_req_ready, mem_rsp_*)
// Signal names keep their _i/_o suffixes as seen from the controller.
interface dcache_refill_ctrl_if #(
    parameter int LINE_WORDS = 32,
    parameter int WORD_WID   = 64,
    parameter int ADDR_WID   = 64
);
    logic                          miss_valid_i;
    logic [ADDR_WID-1:0]           miss_addr_i;
    logic                          miss_ready_o;

    logic                          mem_req_valid_o;
    logic                          mem_req_ready_i;
    logic [ADDR_WID-1:0]           mem_req_addr_o;
    logic [7:0]                    mem_req_len_o;

    logic                          mem_rsp_valid_i;
    logic [WORD_WID-1:0]           mem_rsp_data_i;
    logic                          mem_rsp_last_i;

    logic                          fill_wr_en_o;
    logic [$clog2(LINE_WORDS)-1:0] fill_word_idx_o;
    logic [WORD_WID-1:0]           fill_data_o;
    logic [ADDR_WID-1:0]           fill_line_addr_o;
    logic                          fill_tag_wr_o;
    logic                          crit_valid_o;
    logic [WORD_WID-1:0]           crit_data_o;
    logic                          fill_done_o;
    logic                          fill_err_o;
    logic                          busy_o;

    modport master (
        input  miss_valid_i, miss_addr_i,
        output miss_ready_o,
        output mem_req_valid_o, mem_req_addr_o, mem_req_len_o,
        input  mem_req_ready_i,
        input  mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_last_i,
        output fill_wr_en_o, fill_word_idx_o, fill_data_o, fill_line_addr_o,
        output fill_tag_wr_o, crit_valid_o, crit_data_o,
        output fill_done_o, fill_err_o, busy_o
    );

    modport slave (
        output miss_valid_i, miss_addr_i,
        input  miss_ready_o,
        input  mem_req_valid_o, mem_req_addr_o, mem_req_len_o,
        output mem_req_ready_i,
        output mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_last_i,
        input  fill_wr_en_o, fill_word_idx_o, fill_data_o, fill_line_addr_o,
        input  fill_tag_wr_o, crit_valid_o, crit_data_o,
        input  fill_done_o, fill_err_o, busy_o
    );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler. Accepts one miss at a time, issues a single burst
// read for the whole line, writes the returned beats into the line storage one
// word per cycle (1-cycle registered latency), pulses the critical word, and
// finishes with a one-cycle done pulse that writes the tag unless the burst
// was malformed (early last, or no last on the final beat).
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : dcache_refill_ctrl_if.master (miss, mem request/response, fill)
//
// Build option DCACHE_REFILL_CRIT_FIRST_EN: request starts at the word-aligned
// miss address, memory wraps, and the critical word is the first one written.
//
// state | meaning
// IDLE  | ready for a miss
// REQ   | burst request outstanding
// FILL  | collecting beats; end_q marks the final write cycle
// DONE  | one-cycle completion / tag write
module dcache_refill_ctrl #(
    parameter int LINE_WORDS = 32,
    parameter int WORD_WID   = 64,
    parameter int ADDR_WID   = 64
) (
    input logic                clk_i,
    input logic                rst_i,
    dcache_refill_ctrl_if.master bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int WB_W  = $clog2(WORD_WID / 8);
    localparam int OFF_W = IDX_W + WB_W;

    localparam logic [ADDR_WID-1:0] LINE_MASK = {ADDR_WID{1'b1}} << OFF_W;
    localparam logic [ADDR_WID-1:0] WORD_MASK = {ADDR_WID{1'b1}} << WB_W;
    localparam logic [IDX_W-1:0]    LAST_CNT  = IDX_W'(LINE_WORDS - 1);
    localparam logic [7:0]          BURST_LEN = 8'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_WID-1:0] line_addr_q, line_addr_d;
    logic [ADDR_WID-1:0] req_addr_q, req_addr_d;
    logic [IDX_W-1:0]    crit_idx_q, crit_idx_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                end_q, end_d;
    logic                err_q, err_d;
    logic                wr_en_q, wr_en_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    logic [WORD_WID-1:0] wdata_q, wdata_d;
    logic                crit_q, crit_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            line_addr_q <= '0;
            req_addr_q  <= '0;
            crit_idx_q  <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            widx_q      <= '0;
            wdata_q     <= '0;
            crit_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            req_addr_q  <= req_addr_d;
            crit_idx_q  <= crit_idx_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            end_q       <= end_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            crit_q      <= crit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        req_addr_d  = req_addr_q;
        crit_idx_d  = crit_idx_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        end_d       = end_q;
        err_d       = err_q;
        wr_en_d     = 1'b0;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        crit_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.miss_valid_i) begin
                    line_addr_d = bus.miss_addr_i & LINE_MASK;
`ifdef DCACHE_REFILL_CRIT_FIRST_EN
                    req_addr_d  = bus.miss_addr_i & WORD_MASK;
`else
                    req_addr_d  = bus.miss_addr_i & LINE_MASK;
`endif
                    crit_idx_d  = bus.miss_addr_i[WB_W +: IDX_W];
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready_i) begin
                    cnt_d   = '0;
                    end_d   = 1'b0;
                    err_d   = 1'b0;
`ifdef DCACHE_REFILL_CRIT_FIRST_EN
                    idx_d   = crit_idx_q;
`else
                    idx_d   = '0;
`endif
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // end_q: the final beat was taken last cycle and its write is
                // on the outputs now; DONE follows this write cycle.
                if (end_q) begin
                    state_d = S_DONE;
                end else if (bus.mem_rsp_valid_i) begin
                    wr_en_d = 1'b1;
                    widx_d  = idx_q;
                    wdata_d = bus.mem_rsp_data_i;
`ifdef DCACHE_REFILL_CRIT_FIRST_EN
                    crit_d  = (cnt_q == '0);
`else
                    crit_d  = (idx_q == crit_idx_q);
`endif
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    // Errors are judged on the beat count, never on the index.
                    if (bus.mem_rsp_last_i || (cnt_q == LAST_CNT)) begin
                        end_d = 1'b1;
                        err_d = !(bus.mem_rsp_last_i && (cnt_q == LAST_CNT));
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.miss_ready_o     = (state_q == S_IDLE);
    assign bus.mem_req_valid_o  = (state_q == S_REQ);
    assign bus.mem_req_addr_o   = req_addr_q;
    assign bus.mem_req_len_o    = (state_q == S_REQ) ? BURST_LEN : 8'd0;
    assign bus.fill_wr_en_o     = wr_en_q;
    assign bus.fill_word_idx_o  = widx_q;
    assign bus.fill_data_o      = wdata_q;
    assign bus.fill_line_addr_o = line_addr_q;
    assign bus.crit_valid_o     = crit_q;
    assign bus.crit_data_o      = wdata_q;
    assign bus.fill_done_o      = (state_q == S_DONE);
    assign bus.fill_tag_wr_o    = (state_q == S_DONE) && !err_q;
    assign bus.fill_err_o       = (state_q == S_DONE) && err_q;
    assign bus.busy_o           = (state_q != S_IDLE);
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
module tb_dcache_refill_ctrl;
    localparam int LW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_refill_ctrl_if #(.LINE_WORDS(LW), .WORD_WID(64), .ADDR_WID(64)) bus ();

    dcache_refill_ctrl #(.LINE_WORDS(LW), .WORD_WID(64), .ADDR_WID(64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] addr;
        int          last_at;     // beat carrying last, -1 = never
        int          gap;         // idle cycle after each beat
        int          stall;       // cycles with mem_req_ready low
        int          exp_writes;
        logic        exp_err;
        logic [63:0] exp_line;
    } vec_t;

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic        crit;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_wr_cyc = -10;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic        exp_err = 1'b0;
    logic [63:0] exp_line = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every fill write is popped and compared.
    wr_t mon_e;
    always @(negedge clk) begin
        cyc++;
        if (bus.fill_wr_en_o) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(bus.fill_word_idx_o), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_idx", 64'(bus.fill_word_idx_o), 64'(mon_e.idx));
                chk("wr_data", bus.fill_data_o, mon_e.data);
                chk("wr_crit", 64'(bus.crit_valid_o), 64'(mon_e.crit));
                chk("wr_line", bus.fill_line_addr_o, exp_line);
                if (mon_e.crit) chk("crit_data", bus.crit_data_o, mon_e.data);
            end
        end else begin
            chk("crit_no_write", 64'(bus.crit_valid_o), 64'd0);
        end
        if (bus.fill_done_o) begin
            done_cnt++;
            chk("done_timing", 64'(cyc), 64'(last_wr_cyc + 1));
            chk("done_tag", 64'(bus.fill_tag_wr_o), 64'(!exp_err));
            chk("done_err", 64'(bus.fill_err_o), 64'(exp_err));
        end
    end

    task automatic run_vec(input vec_t v, input int id);
        int          n, start, crit;
        wr_t         e;
        logic [63:0] req;
        crit = int'(v.addr[7:3]);
`ifdef DCACHE_REFILL_CRIT_FIRST_EN
        start = crit;
        req   = v.addr & ~64'h7;
`else
        start = 0;
        req   = v.addr & ~64'hFF;
`endif
        n = (v.last_at < 0) ? LW : v.last_at + 1;
        exp_err  = v.exp_err;
        exp_line = v.exp_line;
        done_cnt = 0;
        wr_cnt   = 0;

        bus.miss_valid_i = 1'b1;
        bus.miss_addr_i  = v.addr;
        chk("miss_ready_idle", 64'(bus.miss_ready_o), 64'd1);
        step();
        bus.miss_valid_i = 1'b0;
        chk("busy_req", 64'(bus.busy_o), 64'd1);
        for (int s = 0; s < v.stall; s++) begin
            chk("stall_valid", 64'(bus.mem_req_valid_o), 64'd1);
            chk("stall_addr", bus.mem_req_addr_o, req);
            chk("stall_no_wr", 64'(bus.fill_wr_en_o), 64'd0);
            step();
        end
        bus.mem_req_ready_i = 1'b1;
        chk("req_valid", 64'(bus.mem_req_valid_o), 64'd1);
        chk("req_addr", bus.mem_req_addr_o, req);
        chk("req_len", 64'(bus.mem_req_len_o), 64'd31);
        step();
        bus.mem_req_ready_i = 1'b0;
        chk("req_dropped", 64'(bus.mem_req_valid_o), 64'd0);

        for (int b = 0; b < n; b++) begin
            e.idx  = (start + b) % LW;
            e.data = {32'(id + 1), 32'(b)};
`ifdef DCACHE_REFILL_CRIT_FIRST_EN
            e.crit = (b == 0);
`else
            e.crit = (e.idx == crit);
`endif
            exp_q.push_back(e);
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_data_i  = e.data;
            bus.mem_rsp_last_i  = (b == v.last_at);
            step();
            if (v.gap != 0) begin
                bus.mem_rsp_valid_i = 1'b0;
                bus.mem_rsp_last_i  = 1'b0;
                step();
            end
        end
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_last_i  = 1'b0;
        repeat (6) step();
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("write_count", 64'(wr_cnt), 64'(v.exp_writes));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_after", 64'(bus.busy_o), 64'd0);
    endtask

    vec_t vecs[6];
    wr_t  e0;

    initial begin
        vecs[0] = '{64'h1238, 31, 0, 0, 32, 1'b0, 64'h1200};
        vecs[1] = '{64'h1238, 31, 0, 5, 32, 1'b0, 64'h1200};
        vecs[2] = '{64'h3418, 31, 1, 0, 32, 1'b0, 64'h3400};
        vecs[3] = '{64'h1238, 10, 0, 0, 11, 1'b1, 64'h1200};
        vecs[4] = '{64'hFFF8, -1, 0, 2, 32, 1'b1, 64'hFF00};
        vecs[5] = '{64'h2000,  0, 0, 0,  1, 1'b1, 64'h2000};

        bus.miss_valid_i    = 1'b0;
        bus.miss_addr_i     = '0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;
        bus.mem_rsp_last_i  = 1'b0;

        rst = 1'b1;
        repeat (3) step();
        chk("rst_miss_ready", 64'(bus.miss_ready_o), 64'd1);
        chk("rst_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        chk("rst_req_addr", bus.mem_req_addr_o, 64'd0);
        chk("rst_req_len", 64'(bus.mem_req_len_o), 64'd0);
        chk("rst_wr_en", 64'(bus.fill_wr_en_o), 64'd0);
        chk("rst_line", bus.fill_line_addr_o, 64'd0);
        chk("rst_done", 64'(bus.fill_done_o), 64'd0);
        chk("rst_tag", 64'(bus.fill_tag_wr_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        step();

        // Beats while idle must be ignored.
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 64'hDEAD;
        repeat (3) begin
            step();
            chk("idle_beat_ignored", 64'(bus.fill_wr_en_o), 64'd0);
        end
        bus.mem_rsp_valid_i = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset at beat 15, with a competing miss raised mid-burst.
        exp_line = 64'h1200;
        done_cnt = 0;
        bus.miss_valid_i = 1'b1;
        bus.miss_addr_i  = 64'h1238;
        step();
        bus.miss_valid_i    = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        step();
        bus.mem_req_ready_i = 1'b0;
        for (int b = 0; b < 15; b++) begin
`ifdef DCACHE_REFILL_CRIT_FIRST_EN
            e0.idx  = (7 + b) % LW;
            e0.crit = (b == 0);
`else
            e0.idx  = b;
            e0.crit = (b == 7);
`endif
            e0.data = {32'hAB, 32'(b)};
            exp_q.push_back(e0);
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_data_i  = e0.data;
            if (b == 5) begin
                bus.miss_valid_i = 1'b1;
                bus.miss_addr_i  = 64'h9990;
                chk("busy_not_ready", 64'(bus.miss_ready_o), 64'd0);
            end
            step();
            bus.miss_valid_i = 1'b0;
        end
        chk("line_kept", bus.fill_line_addr_o, 64'h1200);
        rst = 1'b1;
        bus.mem_rsp_data_i = {32'hAB, 32'd15};
        step();
        rst = 1'b0;
        chk("rst_mid_no_wr", 64'(bus.fill_wr_en_o), 64'd0);
        step();
        chk("ready_after_rst", 64'(bus.miss_ready_o), 64'd1);
        repeat (4) begin
            step();
            chk("stray_no_wr", 64'(bus.fill_wr_en_o), 64'd0);
        end
        bus.mem_rsp_valid_i = 1'b0;
        step();
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
